reg_file_scoreboard: RTL and testbench

- Architectural register file and write-hazard scoreboard for the multicycle pipelined MIPS core.
- Consumer end of the write-back interface: it takes write-back's valid, write-enable, destination address and data, and commits the data to storage.
- Serves two combinational read ports to decode.
- Tracks in-flight destination writes per register so decode can stall on RAW hazards.

---
 rtl/reg_file_scoreboard.sv | 134 +++++++++++++
 tb/tb_reg_file_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scoreboard
// Brief    : Architectural register file with two combinational read ports
//            and a per-register pending-write scoreboard for RAW stalls.
//            Optional same-cycle write-through, enabled by defining the
//            macro REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_dest,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              src_stall,
  output logic              dest_full,
  output logic              err_underflow
);

  localparam int               NREGS   = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Entry 0 is reset to zero and never written; reads of r0 are forced to
  // zero anyway so its contents never matter.
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  cnt_q  [NREGS];
  logic [CNT_W-1:0]  cnt_d  [NREGS];
  logic              err_q;

  logic w_commit;
  logic w_inc;
  logic w_same;
  logic w_underflow;
  logic w_rs_pend;
  logic w_rt_pend;

  // Write-back commit, issue increment and their interaction
  always_comb begin
    w_commit    = wb_valid && wb_we && (wb_addr != '0);
    dest_full   = iss_we && (iss_dest != '0) && (cnt_q[iss_dest] == CNT_MAX);
    w_inc       = iss_valid && iss_we && (iss_dest != '0) && !dest_full;
    // A balanced inc/dec on one register cancels and can never underflow
    w_same      = w_inc && w_commit && (iss_dest == wb_addr);
    w_underflow = w_commit && !w_same && (cnt_q[wb_addr] == '0);
  end

  // Next-state of every pending-write counter; r0 never matches inc/dec
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (w_inc && (iss_dest == ADDR_W'(i)) &&
          !(w_commit && (wb_addr == ADDR_W'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (w_commit && (wb_addr == ADDR_W'(i)) &&
                   !(w_inc && (iss_dest == ADDR_W'(i))) &&
                   (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // Register storage: commit write-back data on the clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (w_commit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Scoreboard counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (w_underflow) begin
      err_q <= 1'b1;
    end
  end

  assign err_underflow = err_q;

`ifdef REGFILE_BYPASS_EN
  logic w_rs_byp;
  logic w_rt_byp;

  // Read ports with same-cycle write-through; a source whose last pending
  // write retires this cycle no longer needs to stall
  always_comb begin
    w_rs_byp  = w_commit && (wb_addr == rs_addr);
    w_rt_byp  = w_commit && (wb_addr == rt_addr);
    rs_data   = (rs_addr == '0) ? '0 : (w_rs_byp ? wb_data : regs_q[rs_addr]);
    rt_data   = (rt_addr == '0) ? '0 : (w_rt_byp ? wb_data : regs_q[rt_addr]);
    w_rs_pend = (rs_addr != '0) && (cnt_q[rs_addr] != '0) &&
                !(w_rs_byp && (cnt_q[rs_addr] == CNT_ONE));
    w_rt_pend = (rt_addr != '0) && (cnt_q[rt_addr] != '0) &&
                !(w_rt_byp && (cnt_q[rt_addr] == CNT_ONE));
    src_stall = w_rs_pend || w_rt_pend;
  end
`else
  // Read ports from storage only; stall purely from registered counters
  always_comb begin
    rs_data   = (rs_addr == '0) ? '0 : regs_q[rs_addr];
    rt_data   = (rt_addr == '0) ? '0 : regs_q[rt_addr];
    w_rs_pend = (rs_addr != '0) && (cnt_q[rs_addr] != '0);
    w_rt_pend = (rt_addr != '0) && (cnt_q[rt_addr] != '0);
    src_stall = w_rs_pend || w_rt_pend;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_scoreboard
// Brief    : Directed self-checking bench for reg_file_scoreboard. Expected
//            values follow REGFILE_BYPASS_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0, wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        iss_valid = 1'b0, iss_we = 1'b0;
  logic [4:0]  iss_dest = '0, rs_addr = '0, rt_addr = '0;
  logic [31:0] rs_data, rt_data;
  logic        src_stall, dest_full, err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_dest(iss_dest),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .src_stall(src_stall), .dest_full(dest_full), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_we = 0; iss_valid = 0; iss_we = 0;
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1; wb_we = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    iss_valid = 1; iss_we = 1; iss_dest = a;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    n_checks++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs: got %h required %h", rs_data, 32'h0); end
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", src_stall); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_underflow); end
    // fill every register with ones; the last cycle also issues dest 4
    for (int i = 1; i < 32; i++) begin
      commit(5'(i), 32'hFFFF_FFFF);
      if (i == 31) issue(5'd4);
      tick();
    end
    idle(); rs_addr = 5'd4; rt_addr = 5'd31;
    #1;
    n_checks++; if (rs_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL fill_rs: got %h required %h", rs_data, 32'hFFFF_FFFF); end
    n_checks++; if (rt_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL fill_rt: got %h required %h", rt_data, 32'hFFFF_FFFF); end
    n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall: got %b required 1", src_stall); end
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL fill_err: got %b required 1", err_underflow); end
    // asynchronous reset mid-cycle
    #2 rst = 1;
    #1;
    n_checks++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL async_rs: got %h required 0", rs_data); end
    n_checks++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL async_rt: got %h required 0", rt_data); end
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL async_stall: got %b required 0", src_stall); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL async_err: got %b required 0", err_underflow); end
    // a commit held across an edge while in reset must not land
    commit(5'd4, 32'h0000_0055); issue(5'd4);
    tick();
    idle(); rst = 0;
    #1;
    n_checks++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL rst_nowrite: got %h required 0", rs_data); end
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL rst_noinc: got %b required 0", src_stall); end
  endtask

  task automatic test_raw_hazard();
    rs_addr = 5'd5; rt_addr = 5'd0;
    issue(5'd5);
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_after_issue: got %b required 1", src_stall); end
    repeat (2) begin
      tick(); #1;
      n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_idle: got %b required 1", src_stall); end
    end
    tick();
    commit(5'd5, 32'h1234_ABCD);
    #1;
    n_checks++; if (src_stall !== !BYP) begin n_fail++; $display("FAIL raw_stall_commit_cycle: got %b required %b", src_stall, !BYP); end
    n_checks++; if (rs_data !== (BYP ? 32'h1234_ABCD : 32'h0)) begin n_fail++; $display("FAIL raw_rs_commit_cycle: got %h required %h", rs_data, BYP ? 32'h1234_ABCD : 32'h0); end
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL raw_stall_after: got %b required 0", src_stall); end
    n_checks++; if (rs_data !== 32'h1234_ABCD) begin n_fail++; $display("FAIL raw_rs_after: got %h required %h", rs_data, 32'h1234_ABCD); end
  endtask

  task automatic test_reg_zero();
    rs_addr = 5'd0; rt_addr = 5'd0;
    commit(5'd0, 32'hDEAD_BEEF); issue(5'd0);
    #1;
    n_checks++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL r0_rs_during: got %h required 0", rs_data); end
    n_checks++; if (dest_full !== 1'b0) begin n_fail++; $display("FAIL r0_dest_full: got %b required 0", dest_full); end
    tick(); idle(); #1;
    n_checks++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL r0_rt_after: got %h required 0", rt_data); end
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b required 0", src_stall); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL r0_err: got %b required 0", err_underflow); end
  endtask

  task automatic test_saturation();
    rs_addr = 5'd0; rt_addr = 5'd7;
    for (int k = 0; k < 3; k++) begin
      issue(5'd7); #1;
      n_checks++; if (dest_full !== 1'b0) begin n_fail++; $display("FAIL sat_not_full_%0d: got %b required 0", k, dest_full); end
      tick();
    end
    issue(5'd7); #1;
    n_checks++; if (dest_full !== 1'b1) begin n_fail++; $display("FAIL sat_full: got %b required 1", dest_full); end
    n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall: got %b required 1", src_stall); end
    tick();
    iss_valid = 0; #1;
    n_checks++; if (dest_full !== 1'b1) begin n_fail++; $display("FAIL sat_drop: got %b required 1", dest_full); end
    for (int k = 0; k < 3; k++) begin
      commit(5'd7, 32'h7000_0000 + 32'(k));
      tick(); wb_valid = 0; wb_we = 0; #1;
      if (k == 0) begin
        n_checks++; if (dest_full !== 1'b0) begin n_fail++; $display("FAIL sat_unfull: got %b required 0", dest_full); end
      end
      n_checks++; if (src_stall !== (k < 2)) begin n_fail++; $display("FAIL sat_stall_commit_%0d: got %b required %b", k, src_stall, k < 2); end
    end
    n_checks++; if (rt_data !== 32'h7000_0002) begin n_fail++; $display("FAIL sat_rt: got %h required %h", rt_data, 32'h7000_0002); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL sat_err: got %b required 0", err_underflow); end
    idle();
  endtask

  task automatic test_simultaneous();
    rs_addr = 5'd9; rt_addr = 5'd0;
    issue(5'd9);
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL sim_stall_pre: got %b required 1", src_stall); end
    issue(5'd9); commit(5'd9, 32'h9999_0001); #1;
    n_checks++; if (src_stall !== !BYP) begin n_fail++; $display("FAIL sim_stall_during: got %b required %b", src_stall, !BYP); end
    n_checks++; if (rs_data !== (BYP ? 32'h9999_0001 : 32'h0)) begin n_fail++; $display("FAIL sim_rs_during: got %h required %h", rs_data, BYP ? 32'h9999_0001 : 32'h0); end
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL sim_stall_hold: got %b required 1", src_stall); end
    n_checks++; if (rs_data !== 32'h9999_0001) begin n_fail++; $display("FAIL sim_rs: got %h required %h", rs_data, 32'h9999_0001); end
    commit(5'd9, 32'h9999_0002);
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL sim_stall_clear: got %b required 0", src_stall); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL sim_err: got %b required 0", err_underflow); end
  endtask

  task automatic test_back_to_back();
    rs_addr = 5'd12; rt_addr = 5'd13;
    issue(5'd12);
    tick();
    issue(5'd13); commit(5'd12, 32'h0000_000C);
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_both: got %b required 1", src_stall); end
    rt_addr = 5'd0; #1;
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_dec12: got %b required 0", src_stall); end
    rs_addr = 5'd0; rt_addr = 5'd13; #1;
    n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_inc13: got %b required 1", src_stall); end
    commit(5'd13, 32'h0000_000D);
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_clear13: got %b required 0", src_stall); end
  endtask

  task automatic test_underflow();
    rs_addr = 5'd3; rt_addr = 5'd0;
    iss_we = 1; iss_dest = 5'd3; #1;
    n_checks++; if (dest_full !== 1'b0) begin n_fail++; $display("FAIL uf_pre_full: got %b required 0", dest_full); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_pre_err: got %b required 0", err_underflow); end
    iss_we = 0;
    commit(5'd3, 32'h0000_0033);
    tick(); idle(); #1;
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_err_set: got %b required 1", err_underflow); end
    n_checks++; if (rs_data !== 32'h0000_0033) begin n_fail++; $display("FAIL uf_data: got %h required %h", rs_data, 32'h33); end
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL uf_stall: got %b required 0", src_stall); end
    repeat (3) tick();
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b required 1", err_underflow); end
    issue(5'd3);
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b1) begin n_fail++; $display("FAIL uf_cnt_one: got %b required 1", src_stall); end
    commit(5'd3, 32'h0000_0034);
    tick(); idle(); #1;
    n_checks++; if (src_stall !== 1'b0) begin n_fail++; $display("FAIL uf_cnt_zero: got %b required 0", src_stall); end
    rst = 1; #1;
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_rst_clear: got %b required 0", err_underflow); end
    tick(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_reg_zero();
    test_saturation();
    test_simultaneous();
    test_back_to_back();
    test_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
